// File: rtl/bsg_manycore_cache_op_arbiter.sv
// Round-robin arbiter sharing one vcache cache-op port among num_req_p requesters, one op outstanding.
// Optional WAIT timeout enabled by defining BSG_MANYCORE_CACHE_OP_TIMEOUT_EN.
module bsg_manycore_cache_op_arbiter #(
  parameter int num_req_p        = 4,
  parameter int addr_width_p     = 28,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p-1:0]              v_i,
  input  logic [num_req_p*5-1:0]            op_i,
  input  logic [num_req_p*addr_width_p-1:0] addr_i,
  output logic [num_req_p-1:0]              ready_o,
  output logic [num_req_p-1:0]              done_o,
  output logic                              err_o,
  output logic                              cache_v_o,
  output logic [4:0]                        cache_op_o,
  output logic [addr_width_p-1:0]           cache_addr_o,
  input  logic                              cache_ready_i,
  input  logic                              cache_done_i
);

  localparam int ptr_w = $clog2(num_req_p);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_e;

  state_e                    state_r, state_n;
  logic [ptr_w-1:0]          rr_ptr, owner, winner;
  logic                      found, grant;
  logic [4:0]                win_op, op_r;
  logic [addr_width_p-1:0]   win_addr, addr_r;
  logic [num_req_p-1:0]      owner_vec, done_r;
  logic                      err_r;
  logic                      finish_ok, finish_err, timeout_hit;

  // Search starts at rr_ptr and wraps, so the first requester at or after the pointer wins.
  always_comb begin
    int idx;
    idx      = 0;
    found    = 1'b0;
    winner   = '0;
    win_op   = '0;
    win_addr = '0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && v_i[idx]) begin
        found    = 1'b1;
        winner   = ptr_w'(idx);
        win_op   = op_i[5*idx +: 5];
        win_addr = addr_i[addr_width_p*idx +: addr_width_p];
      end
    end
  end

  assign grant = (state_r == IDLE) && found;

  always_comb begin
    ready_o = '0;
    if (grant) ready_o[winner] = 1'b1;
  end

  always_comb begin
    owner_vec        = '0;
    owner_vec[owner] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE:    if (found) state_n = (win_op <= 5'd5) ? ISSUE : ERR;
      ISSUE:   if (cache_ready_i) state_n = WAIT;
      WAIT:    if (cache_done_i || timeout_hit) state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign finish_ok  = (state_r == WAIT) && cache_done_i;
  assign finish_err = (state_r == ERR) || ((state_r == WAIT) && !cache_done_i && timeout_hit);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      op_r   <= '0;
      addr_r <= '0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (grant) begin
      op_r   <= win_op;
      addr_r <= win_addr;
      owner  <= winner;
      rr_ptr <= (winner == ptr_w'(num_req_p - 1)) ? '0 : winner + 1'b1;
    end
  end

  // Completion is registered so done/err appear the cycle after the op finishes.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      done_r <= '0;
      err_r  <= 1'b0;
    end else begin
      done_r <= '0;
      err_r  <= 1'b0;
      if (finish_ok || finish_err) begin
        done_r <= owner_vec;
        err_r  <= finish_err;
      end
    end
  end

`ifdef BSG_MANYCORE_CACHE_OP_TIMEOUT_EN
  localparam int cnt_w = (timeout_cycles_p > 1) ? $clog2(timeout_cycles_p) : 1;

  logic [cnt_w-1:0] wait_cnt;

  // Only ISSUE leads into WAIT, so clearing there resets the count on every WAIT entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             wait_cnt <= '0;
    else if (state_r == ISSUE)  wait_cnt <= '0;
    else if (state_r == WAIT)   wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state_r == WAIT) && (wait_cnt == cnt_w'(timeout_cycles_p - 1));
`else
  localparam int unused_timeout_cycles = timeout_cycles_p;

  assign timeout_hit = 1'b0;
`endif

  assign cache_v_o    = (state_r == ISSUE);
  assign cache_op_o   = op_r;
  assign cache_addr_o = addr_r;
  assign done_o       = done_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_bsg_manycore_cache_op_arbiter.sv
// Directed self-checking bench for bsg_manycore_cache_op_arbiter (4 requesters).
// The timeout scenario is compiled in only with BSG_MANYCORE_CACHE_OP_TIMEOUT_EN.
module tb_bsg_manycore_cache_op_arbiter;

  localparam int N  = 4;
  localparam int AW = 28;
  localparam int TO = 16;

  logic            clk_i = 1'b0;
  logic            reset_n_i;
  logic [N-1:0]    v_i;
  logic [N*5-1:0]  op_i;
  logic [N*AW-1:0] addr_i;
  logic [N-1:0]    ready_o, done_o;
  logic            err_o, cache_v_o;
  logic [4:0]      cache_op_o;
  logic [AW-1:0]   cache_addr_o;
  logic            cache_ready_i, cache_done_i;

  int checks = 0;
  int errors = 0;

  bsg_manycore_cache_op_arbiter #(
    .num_req_p(N), .addr_width_p(AW), .timeout_cycles_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .v_i(v_i), .op_i(op_i), .addr_i(addr_i),
    .ready_o(ready_o), .done_o(done_o), .err_o(err_o), .cache_v_o(cache_v_o),
    .cache_op_o(cache_op_o), .cache_addr_o(cache_addr_o),
    .cache_ready_i(cache_ready_i), .cache_done_i(cache_done_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic apply_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    v_i = '0; op_i = '0; addr_i = '0;
    cache_ready_i = 1'b0; cache_done_i = 1'b0;
    step();
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b0;
    v_i = '0; op_i = '0; addr_i = '0;
    cache_ready_i = 1'b0; cache_done_i = 1'b0;
    settle();
    checks++;
    if ({ready_o, done_o, err_o, cache_v_o, cache_op_o, cache_addr_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got ready=%b done=%b err=%b v=%b op=%h addr=%h expected all 0",
               ready_o, done_o, err_o, cache_v_o, cache_op_o, cache_addr_o);
    end
    step();
    reset_n_i = 1'b1;
  endtask

  task automatic test_single_op();
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b1;
    v_i = 4'b0010; op_i[5*1 +: 5] = 5'd0; addr_i[AW*1 +: AW] = 28'h123;
    settle();
    checks++;
    if (ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL single_ready got %b expected 0010", ready_o); end
    step();
    v_i = '0;
    settle();
    checks++;
    if (cache_v_o !== 1'b1) begin errors++; $display("[TB] FAIL single_cache_v got %b expected 1", cache_v_o); end
    checks++;
    if (cache_addr_o !== 28'h123) begin errors++; $display("[TB] FAIL single_addr got %h expected 123", cache_addr_o); end
    checks++;
    if (ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_ready_busy got %b expected 0000", ready_o); end
    step();
    settle();
    checks++;
    if (done_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_early_done got %b expected 0000", done_o); end
    step();
    settle();
    checks++;
    if (done_o !== 4'b0010) begin errors++; $display("[TB] FAIL single_done got %b expected 0010", done_o); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL single_err got %b expected 0", err_o); end
    step();
    settle();
    checks++;
    if (done_o !== 4'b0000) begin errors++; $display("[TB] FAIL single_done_pulse got %b expected 0000", done_o); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_grant, exp_done;
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b1;
    v_i = 4'b1111;
    for (int r = 0; r < N; r++) begin
      op_i[5*r +: 5]    = 5'(r);
      addr_i[AW*r +: AW] = 28'(32'h10 + r);
    end
    for (int g = 0; g < 9; g++) begin
      exp_grant = 4'b0001 << (g % 4);
      exp_done  = 4'b0001 << ((g + 3) % 4);
      settle();
      checks++;
      if (ready_o !== exp_grant) begin
        errors++; $display("[TB] FAIL rr_grant%0d got %b expected %b", g, ready_o, exp_grant);
      end
      if (g > 0) begin
        checks++;
        if (done_o !== exp_done || err_o !== 1'b0) begin
          errors++; $display("[TB] FAIL rr_done%0d got %b err %b expected %b err 0", g, done_o, err_o, exp_done);
        end
      end
      step();
      settle();
      checks++;
      if (cache_addr_o !== 28'(32'h10 + (g % 4))) begin
        errors++; $display("[TB] FAIL rr_addr%0d got %h expected %h", g, cache_addr_o, 32'h10 + (g % 4));
      end
      if (g == 8) v_i = '0;
      step();
      step();
    end
  endtask

  task automatic test_skip();
    logic [3:0] exp_seq [3];
    exp_seq[0] = 4'b0010; exp_seq[1] = 4'b1000; exp_seq[2] = 4'b0010;
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b1;
    v_i = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      settle();
      checks++;
      if (ready_o !== exp_seq[g]) begin
        errors++; $display("[TB] FAIL skip_grant%0d got %b expected %b", g, ready_o, exp_seq[g]);
      end
      if (g == 2) v_i = '0;
      step(); step(); step();
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b1;
    v_i = 4'b0100; op_i[5*2 +: 5] = 5'd7; addr_i[AW*2 +: AW] = 28'h77;
    settle();
    checks++;
    if (ready_o !== 4'b0100) begin errors++; $display("[TB] FAIL illegal_ready got %b expected 0100", ready_o); end
    step();
    v_i = '0;
    settle();
    checks++;
    if (cache_v_o !== 1'b0 || done_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL illegal_errstate got v=%b done=%b expected v=0 done=0000", cache_v_o, done_o);
    end
    step();
    settle();
    checks++;
    if (done_o !== 4'b0100) begin errors++; $display("[TB] FAIL illegal_done got %b expected 0100", done_o); end
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err got %b expected 1", err_o); end
    checks++;
    if (cache_v_o !== 1'b0) begin errors++; $display("[TB] FAIL illegal_cache_v got %b expected 0", cache_v_o); end
    step();
    settle();
    checks++;
    if (done_o !== 4'b0000 || err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL illegal_pulse got done=%b err=%b expected 0000 0", done_o, err_o);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    cache_ready_i = 1'b0; cache_done_i = 1'b0;
    v_i = 4'b0001; op_i[5*0 +: 5] = 5'd2; addr_i[AW*0 +: AW] = 28'hABCDEF;
    op_i[5*1 +: 5] = 5'd1;
    settle();
    checks++;
    if (ready_o !== 4'b0001) begin errors++; $display("[TB] FAIL stall_grant got %b expected 0001", ready_o); end
    step();
    v_i = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (cache_v_o !== 1'b1 || cache_op_o !== 5'd2 || cache_addr_o !== 28'hABCDEF) begin
        errors++; $display("[TB] FAIL stall_hold%0d got v=%b op=%h addr=%h expected 1 02 abcdef",
                           i, cache_v_o, cache_op_o, cache_addr_o);
      end
      checks++;
      if (ready_o !== 4'b0000) begin errors++; $display("[TB] FAIL stall_ready%0d got %b expected 0000", i, ready_o); end
      step();
    end
    cache_ready_i = 1'b1;
    step();
    cache_ready_i = 1'b0;
    settle();
    checks++;
    if (cache_v_o !== 1'b0 || ready_o !== 4'b0000) begin
      errors++; $display("[TB] FAIL stall_wait got v=%b ready=%b expected 0 0000", cache_v_o, ready_o);
    end
    cache_done_i = 1'b1;
    step();
    cache_done_i = 1'b0;
    settle();
    checks++;
    if (done_o !== 4'b0001 || err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_done got %b err %b expected 0001 err 0", done_o, err_o);
    end
    checks++;
    if (ready_o !== 4'b0010) begin errors++; $display("[TB] FAIL stall_next_grant got %b expected 0010", ready_o); end
    v_i = '0;
  endtask

  task automatic test_reset_in_wait();
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b0;
    v_i = 4'b0001; op_i[5*0 +: 5] = 5'd4; addr_i[AW*0 +: AW] = 28'h55;
    step();
    v_i = '0;
    settle();
    checks++;
    if (cache_op_o !== 5'd4) begin errors++; $display("[TB] FAIL rstwait_op got %h expected 04", cache_op_o); end
    step();
    settle();
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, done_o, err_o, cache_v_o, cache_op_o, cache_addr_o} !== '0) begin
      errors++; $display("[TB] FAIL rstwait_outputs got ready=%b done=%b err=%b v=%b op=%h addr=%h expected all 0",
                         ready_o, done_o, err_o, cache_v_o, cache_op_o, cache_addr_o);
    end
    step();
    reset_n_i = 1'b1;
    cache_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (done_o !== 4'b0000 || err_o !== 1'b0) begin
        errors++; $display("[TB] FAIL rstwait_stray%0d got done=%b err=%b expected 0000 0", i, done_o, err_o);
      end
      step();
    end
    cache_done_i = 1'b0;
  endtask

`ifdef BSG_MANYCORE_CACHE_OP_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    cache_ready_i = 1'b1; cache_done_i = 1'b0;
    v_i = 4'b0001; op_i[5*0 +: 5] = 5'd1; addr_i[AW*0 +: AW] = 28'h9;
    step();
    v_i = '0;
    step();
    for (int i = 0; i < TO; i++) begin
      settle();
      checks++;
      if (done_o !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_early%0d got %b expected 0000", i, done_o); end
      step();
    end
    settle();
    checks++;
    if (done_o !== 4'b0001 || err_o !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_done got %b err %b expected 0001 err 1", done_o, err_o);
    end
    cache_done_i = 1'b1;
    step();
    cache_done_i = 1'b0;
    settle();
    checks++;
    if (done_o !== 4'b0000) begin errors++; $display("[TB] FAIL timeout_stray got %b expected 0000", done_o); end
    v_i = 4'b0001;
    step();
    v_i = '0;
    step();
    for (int i = 0; i < TO - 1; i++) step();
    cache_done_i = 1'b1;
    step();
    cache_done_i = 1'b0;
    settle();
    checks++;
    if (done_o !== 4'b0001 || err_o !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout_lastcycle got %b err %b expected 0001 err 0", done_o, err_o);
    end
  endtask
`endif

  initial begin
    $display("[TB] starting bsg_manycore_cache_op_arbiter bench");
    test_reset();
    test_single_op();
    test_round_robin();
    test_skip();
    test_illegal();
    test_stall();
    test_reset_in_wait();
`ifdef BSG_MANYCORE_CACHE_OP_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
